// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg: default 800x480 panel timing, pattern encodings and RGB565 bar colours.
package lcd_timing_pkg;
    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 48;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 13;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 32;
    localparam bit DEF_SYNC_POL = 1'b0;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_SOLID    = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_GRADIENT = 2'd3
    } pat_t;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        return idx == 3'd0 ? RGB_WHITE
             : idx == 3'd1 ? RGB_YELLOW
             : idx == 3'd2 ? RGB_CYAN
             : idx == 3'd3 ? RGB_GREEN
             : idx == 3'd4 ? RGB_MAGENTA
             : idx == 3'd5 ? RGB_RED
             : idx == 3'd6 ? RGB_BLUE
             : RGB_BLACK;
    endfunction
endpackage

// File: rtl/lcd_timing_gen_if.sv
// lcd_timing_gen_if: control inputs and registered LCD/pixel-coordinate outputs of the timing stage.
interface lcd_timing_gen_if;
    logic        en;
    logic [1:0]  pat_sel;
    logic [15:0] solid_rgb;
    logic        lcd_de;
    logic        lcd_hsync;
    logic        lcd_vsync;
    logic [4:0]  lcd_r;
    logic [5:0]  lcd_g;
    logic [4:0]  lcd_b;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic        frame_start;

    modport master (
        input  en, pat_sel, solid_rgb,
        output lcd_de, lcd_hsync, lcd_vsync, lcd_r, lcd_g, lcd_b, pix_x, pix_y, frame_start
    );

    modport slave (
        output en, pat_sel, solid_rgb,
        input  lcd_de, lcd_hsync, lcd_vsync, lcd_r, lcd_g, lcd_b, pix_x, pix_y, frame_start
    );
endinterface

// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: maps pixel position to an RGB565 test pattern; pattern/colour shadowed per frame.
module lcd_pattern_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample,
    input  logic [1:0]  pat_sel,
    input  logic [15:0] solid_rgb,
    input  logic [10:0] x,
    input  logic        y5,
    output logic [15:0] rgb
);
    localparam logic [10:0] BAR_W = 11'(H_ACTIVE >= 8 ? H_ACTIVE / 8 : 1);

    pat_t        pat_q, pat;
    logic [15:0] solid_q, solid;
    logic [10:0] bar;

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= PAT_BARS;
            solid_q <= '0;
        end else if (sample) begin
            pat_q   <= pat_t'(pat_sel);
            solid_q <= solid_rgb;
        end
    end

    // The first pixel of a frame already uses the value being sampled on that clock.
    assign pat   = sample ? pat_t'(pat_sel) : pat_q;
    assign solid = sample ? solid_rgb : solid_q;
    assign bar   = x / BAR_W;

    always_comb begin
        rgb = pat == PAT_BARS    ? bar_colour(bar > 11'd7 ? 3'd7 : bar[2:0])
            : pat == PAT_SOLID   ? solid
            : pat == PAT_CHECKER ? {16{x[5] ^ y5}}
            : {x[9:5], x[9:4], x[9:5]};
    end
endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: parallel-LCD hsync/vsync/DE timing with registered test-pattern and coordinate outputs.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input logic clk,
    input logic rst,
    lcd_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        H_TOTAL > 2047 || V_TOTAL > 1023) begin : g_bad_params
        $error("lcd_timing_gen: illegal timing parameters");
    end

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        h_wrap, de_c, hs_c, vs_c, fs_c;
    logic [15:0] pat_rgb;

    assign h_wrap = h_cnt == H_LAST;
    assign de_c   = bus.en && h_cnt < H_ACT && v_cnt < V_ACT;
    assign hs_c   = bus.en && h_cnt >= HS_BEG && h_cnt < HS_END;
    assign vs_c   = bus.en && v_cnt >= VS_BEG && v_cnt < VS_END;
    assign fs_c   = bus.en && h_cnt == '0 && v_cnt == '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (bus.en) begin
            h_cnt <= h_wrap ? '0 : h_cnt + 11'd1;
            if (h_wrap) v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + 10'd1;
        end
    end

    lcd_pattern_gen #(.H_ACTIVE(H_ACTIVE)) u_pat (
        .clk       (clk),
        .rst       (rst),
        .sample    (fs_c),
        .pat_sel   (bus.pat_sel),
        .solid_rgb (bus.solid_rgb),
        .x         (h_cnt),
        .y5        (v_cnt[5]),
        .rgb       (pat_rgb)
    );

    // Single output stage keeps DE, syncs, colour and coordinates mutually aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.lcd_de                        <= 1'b0;
            bus.lcd_hsync                     <= !SYNC_POL;
            bus.lcd_vsync                     <= !SYNC_POL;
            bus.frame_start                   <= 1'b0;
            {bus.lcd_r, bus.lcd_g, bus.lcd_b} <= '0;
            bus.pix_x                         <= '0;
            bus.pix_y                         <= '0;
        end else begin
            bus.lcd_de                        <= de_c;
            bus.lcd_hsync                     <= hs_c ^ !SYNC_POL;
            bus.lcd_vsync                     <= vs_c ^ !SYNC_POL;
            bus.frame_start                   <= fs_c;
            {bus.lcd_r, bus.lcd_g, bus.lcd_b} <= de_c ? pat_rgb : '0;
            bus.pix_x                         <= de_c ? h_cnt : '0;
            bus.pix_y                         <= de_c ? v_cnt : '0;
        end
    end
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: scoreboard bench on a shrunken panel; one DUT per sync polarity.
module tb_lcd_timing_gen;
    localparam int HA = 64, HF = 4, HS = 6, HB = 6;
    localparam int VA = 40, VF = 2, VS = 3, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam logic [40:0] IDLE_A = {1'b0, 2'b11, 38'd0};
    localparam logic [40:0] IDLE_B = '0;

    typedef struct packed {
        logic        de, hs, vs, fs;
        logic [15:0] rgb;
        logic [10:0] x;
        logic [9:0]  y;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    lcd_timing_gen_if ia ();
    lcd_timing_gen_if ib ();

    lcd_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
                     .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    lcd_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
                     .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    exp_t q[$];
    exp_t e;
    int hm = 0, vm = 0, pm = 0;
    logic [15:0] sm = '0;
    logic [15:0] rgb_a, rgb_b;
    logic [40:0] out_a, out_b;

    assign rgb_a = {ia.lcd_r, ia.lcd_g, ia.lcd_b};
    assign rgb_b = {ib.lcd_r, ib.lcd_g, ib.lcd_b};
    assign out_a = {ia.lcd_de, ia.lcd_hsync, ia.lcd_vsync, ia.frame_start, rgb_a, ia.pix_x, ia.pix_y};
    assign out_b = {ib.lcd_de, ib.lcd_hsync, ib.lcd_vsync, ib.frame_start, rgb_b, ib.pix_x, ib.pix_y};

    function automatic logic [40:0] pack_exp(exp_t ex, logic pol);
        return {ex.de, ex.hs ? pol : !pol, ex.vs ? pol : !pol, ex.fs, ex.rgb, ex.x, ex.y};
    endfunction

    function automatic logic [15:0] ref_pix(int p, logic [15:0] s, int x, int y);
        logic [15:0] r;
        r = '0;
        case (p)
            0: case (x / (HA / 8))
                   0: r = 16'hFFFF;
                   1: r = 16'hFFE0;
                   2: r = 16'h07FF;
                   3: r = 16'h07E0;
                   4: r = 16'hF81F;
                   5: r = 16'hF800;
                   6: r = 16'h001F;
                   default: r = 16'h0000;
               endcase
            1: r = s;
            2: r = ((x / 32 + y / 32) % 2 == 1) ? 16'hFFFF : 16'h0000;
            default: r = {5'((x / 32) % 32), 6'((x / 16) % 64), 5'((x / 32) % 32)};
        endcase
        return r;
    endfunction

    // Reference model: predicts the output each clock produces and queues it.
    function automatic void model_tick();
        exp_t ex;
        ex = '0;
        if (rst) begin
            hm = 0; vm = 0; pm = 0; sm = '0;
        end else if (ia.en) begin
            if (hm == 0 && vm == 0) begin
                pm = int'(ia.pat_sel);
                sm = ia.solid_rgb;
            end
            ex.de = hm < HA && vm < VA;
            ex.hs = hm >= HA + HF && hm < HA + HF + HS;
            ex.vs = vm >= VA + VF && vm < VA + VF + VS;
            ex.fs = hm == 0 && vm == 0;
            if (ex.de) begin
                ex.x   = 11'(hm);
                ex.y   = 10'(vm);
                ex.rgb = ref_pix(pm, sm, hm, vm);
            end
            hm++;
            if (hm == HT) begin
                hm = 0;
                vm = (vm + 1) % VT;
            end
        end
        q.push_back(ex);
    endfunction

    always @(posedge clk) model_tick();

    task automatic step();
        @(negedge clk);
        if (q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty got=0 exp>=1");
        end else e = q.pop_front();
    endtask

    task automatic drive(logic en, logic [1:0] p, logic [15:0] s);
        ia.en = en; ia.pat_sel = p; ia.solid_rgb = s;
        ib.en = en; ib.pat_sel = p; ib.solid_rgb = s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 2'd0, 16'h0);
        repeat (3) step();
        checks++;
        if (out_a !== IDLE_A) begin failures++; $display("FAIL reset_a got=%h exp=%h", out_a, IDLE_A); end
        checks++;
        if (out_b !== IDLE_B) begin failures++; $display("FAIL reset_b got=%h exp=%h", out_b, IDLE_B); end
    endtask

    task automatic test_frames();
        int last_hs = -1, hs_run = 0, last_fs = -1, de_n = 0, vs_n = 0;
        logic hs_prev = 1'b1;
        rst = 1'b0;
        drive(1'b1, 2'd0, 16'h0);
        for (int i = 0; i < 2 * FT; i++) begin
            step();
            checks++;
            if (out_a !== pack_exp(e, 1'b0) || out_b !== pack_exp(e, 1'b1)) begin
                failures++;
                $display("FAIL frames_out cyc=%0d got_a=%h got_b=%h exp_a=%h", i, out_a, out_b, pack_exp(e, 1'b0));
            end
            if (i == 0) begin
                checks++;
                if (ia.frame_start !== 1'b1) begin failures++; $display("FAIL first_frame_start got=%b exp=1", ia.frame_start); end
            end
            if (ia.lcd_hsync === 1'b0 && hs_prev === 1'b1) begin
                if (last_hs >= 0) begin
                    checks++;
                    if (i - last_hs != HT) begin failures++; $display("FAIL hsync_period got=%0d exp=%0d", i - last_hs, HT); end
                end
                last_hs = i;
            end
            if (ia.lcd_hsync === 1'b1 && hs_prev === 1'b0) begin
                checks++;
                if (hs_run != HS) begin failures++; $display("FAIL hsync_width got=%0d exp=%0d", hs_run, HS); end
            end
            hs_run  = (ia.lcd_hsync === 1'b0) ? hs_run + 1 : 0;
            hs_prev = ia.lcd_hsync;
            if (ia.frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (i - last_fs != FT) begin failures++; $display("FAIL frame_period got=%0d exp=%0d", i - last_fs, FT); end
                end
                last_fs = i;
            end
            if (ia.lcd_de === 1'b1) de_n++;
            if (ia.lcd_vsync === 1'b0) vs_n++;
        end
        checks++;
        if (de_n != 2 * HA * VA) begin failures++; $display("FAIL de_count got=%0d exp=%0d", de_n, 2 * HA * VA); end
        checks++;
        if (vs_n != 2 * VS * HT) begin failures++; $display("FAIL vsync_width got=%0d exp=%0d", vs_n, 2 * VS * HT); end
        checks++;
        if (last_fs != FT) begin failures++; $display("FAIL second_frame_start got=%0d exp=%0d", last_fs, FT); end
    endtask

    task automatic test_bars();
        int changes = 0;
        logic [15:0] prev = '0;
        for (int i = 0; i < HT; i++) begin
            step();
            checks++;
            if (out_a !== pack_exp(e, 1'b0)) begin failures++; $display("FAIL bars_out got=%h exp=%h", out_a, pack_exp(e, 1'b0)); end
            if (ia.lcd_de === 1'b1) begin
                if (ia.pix_x == 0) begin
                    checks++;
                    if (rgb_a !== 16'hFFFF) begin failures++; $display("FAIL bar_x0 got=%h exp=ffff", rgb_a); end
                end
                if (ia.pix_x == 8) begin
                    checks++;
                    if (rgb_a !== 16'hFFE0) begin failures++; $display("FAIL bar_x8 got=%h exp=ffe0", rgb_a); end
                end
                if (ia.pix_x == HA - 1) begin
                    checks++;
                    if (rgb_a !== 16'h0000) begin failures++; $display("FAIL bar_last got=%h exp=0000", rgb_a); end
                end
                if (ia.pix_x != 0 && rgb_a !== prev) begin
                    changes++;
                    checks++;
                    if (ia.pix_x % 8 != 0) begin failures++; $display("FAIL bar_edge got_x=%0d exp=multiple_of_8", ia.pix_x); end
                end
                prev = rgb_a;
            end
        end
        checks++;
        if (changes != 7) begin failures++; $display("FAIL bar_changes got=%0d exp=7", changes); end
    endtask

    task automatic test_solid();
        int n = 0;
        bit found = 0;
        while (vm != 20 && n < FT) begin step(); n++; end
        drive(1'b1, 2'd1, 16'hF800);
        n = 0;
        while (!found && n < 2 * FT) begin
            step();
            n++;
            checks++;
            if (out_a !== pack_exp(e, 1'b0)) begin failures++; $display("FAIL solid_out got=%h exp=%h", out_a, pack_exp(e, 1'b0)); end
            if (ia.frame_start === 1'b1) begin
                found = 1;
                checks++;
                if ({ia.lcd_r, ia.lcd_g, ia.lcd_b} !== {5'd31, 6'd0, 5'd0})
                    begin failures++; $display("FAIL solid_first_pixel got=%h exp=f800", rgb_a); end
            end else if (ia.lcd_de === 1'b1 && ia.pix_x == 8) begin
                checks++;
                if (rgb_a !== 16'hFFE0) begin failures++; $display("FAIL solid_old_frame got=%h exp=ffe0", rgb_a); end
            end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL solid_timeout got=none exp=frame_start"); end
    endtask

    task automatic test_en_gap();
        int n = 0, cnt = 0;
        while (!(ia.lcd_de === 1'b1 && ia.pix_y == 10 && ia.pix_x == 0) && n < 2 * FT) begin step(); n++; end
        while (hm != 40 && n < 2 * FT) begin step(); n++; cnt++; end
        drive(1'b0, 2'd1, 16'hF800);
        for (int i = 0; i < 50; i++) begin
            step();
            checks++;
            if ({ia.lcd_de, ia.lcd_hsync, ia.lcd_vsync, ia.frame_start, rgb_a, ib.lcd_hsync, ib.lcd_vsync} !== {4'b0110, 16'h0, 2'b00})
                begin failures++; $display("FAIL gap_idle got=%h exp=idle", out_a); end
        end
        drive(1'b1, 2'd1, 16'hF800);
        step();
        cnt++;
        checks++;
        if ({ia.lcd_de, ia.pix_x, ia.pix_y} !== {1'b1, 11'd40, 10'd10})
            begin failures++; $display("FAIL gap_resume got_x=%0d got_de=%b exp_x=40", ia.pix_x, ia.lcd_de); end
        while (!(ia.lcd_de === 1'b1 && ia.pix_y == 11 && ia.pix_x == 0) && n < 4 * FT) begin
            step(); n++; cnt++;
            checks++;
            if (out_a !== pack_exp(e, 1'b0)) begin failures++; $display("FAIL gap_out got=%h exp=%h", out_a, pack_exp(e, 1'b0)); end
        end
        checks++;
        if (cnt != HT) begin failures++; $display("FAIL gap_line_len got=%0d exp=%0d", cnt, HT); end
    endtask

    task automatic test_rst_mid();
        int n = 0, low = 0, edges = 0;
        logic prev = 1'b1;
        while (!(vm == 30 && hm == 20) && n < 2 * FT) begin step(); n++; end
        rst = 1'b1;
        step();
        checks++;
        if (out_a !== IDLE_A) begin failures++; $display("FAIL rst_mid_a got=%h exp=%h", out_a, IDLE_A); end
        checks++;
        if (out_b !== IDLE_B) begin failures++; $display("FAIL rst_mid_b got=%h exp=%h", out_b, IDLE_B); end
        rst = 1'b0;
        step();
        checks++;
        if (ia.frame_start !== 1'b1 || out_a !== pack_exp(e, 1'b0))
            begin failures++; $display("FAIL rst_frame_start got=%h exp=%h", out_a, pack_exp(e, 1'b0)); end
        for (int i = 0; i < HT - 1; i++) begin
            step();
            checks++;
            if (out_a !== pack_exp(e, 1'b0)) begin failures++; $display("FAIL rst_line_out got=%h exp=%h", out_a, pack_exp(e, 1'b0)); end
            if (ia.lcd_hsync === 1'b0) low++;
            if (ia.lcd_hsync === 1'b0 && prev === 1'b1) edges++;
            prev = ia.lcd_hsync;
        end
        checks++;
        if (low != HS || edges != 1) begin failures++; $display("FAIL rst_hsync got_low=%0d got_edges=%0d exp=%0d/1", low, edges, HS); end
    endtask

    task automatic test_checker();
        int n = 0, hi = 0;
        drive(1'b1, 2'd2, 16'hF800);
        while (ib.frame_start !== 1'b1 && n < 2 * FT) begin step(); n++; end
        checks++;
        if ({ib.lcd_hsync, ib.lcd_vsync, rgb_b} !== {2'b00, 16'h0000})
            begin failures++; $display("FAIL checker_origin got=%h exp=syncs_low_black", out_b); end
        for (int i = 0; i < 33 * HT; i++) begin
            step();
            checks++;
            if (out_b !== pack_exp(e, 1'b1)) begin failures++; $display("FAIL checker_out got=%h exp=%h", out_b, pack_exp(e, 1'b1)); end
            if (i < HT - 1 && ib.lcd_hsync === 1'b1) hi++;
            if (ib.lcd_de === 1'b1 && ib.pix_x == 32 && ib.pix_y == 0) begin
                checks++;
                if (rgb_b !== 16'hFFFF) begin failures++; $display("FAIL checker_32_0 got=%h exp=ffff", rgb_b); end
            end
            if (ib.lcd_de === 1'b1 && ib.pix_x == 32 && ib.pix_y == 32) begin
                checks++;
                if (rgb_b !== 16'h0000) begin failures++; $display("FAIL checker_32_32 got=%h exp=0000", rgb_b); end
            end
        end
        checks++;
        if (hi != HS) begin failures++; $display("FAIL pos_hsync_width got=%0d exp=%0d", hi, HS); end
    endtask

    task automatic test_gradient();
        int n = 0;
        drive(1'b1, 2'd3, 16'h0);
        while (ia.frame_start !== 1'b1 && n < 2 * FT) begin step(); n++; end
        for (int i = 0; i < HA - 1; i++) begin
            step();
            if (ia.pix_x == 16) begin
                checks++;
                if (rgb_a !== {5'd0, 6'd1, 5'd0}) begin failures++; $display("FAIL grad_x16 got=%h exp=%h", rgb_a, {5'd0, 6'd1, 5'd0}); end
            end
            if (ia.pix_x == HA - 1) begin
                checks++;
                if (rgb_a !== {5'd1, 6'd3, 5'd1}) begin failures++; $display("FAIL grad_x63 got=%h exp=%h", rgb_a, {5'd1, 6'd3, 5'd1}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_bars();
        test_solid();
        test_en_gap();
        test_rst_mid();
        test_checker();
        test_gradient();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
